// File: rtl/data_logger_pkg.sv
// rtl/data_logger_pkg.sv - shared mode constants and record sizing for the data logger
package data_logger_pkg;

    localparam logic MODE_AVG  = 1'b0;
    localparam logic MODE_PASS = 1'b1;

    function automatic int rec_width(input int num_ch, input int data_w);
        return $clog2(num_ch) + data_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through record FIFO with synchronous flush
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign rdata   = mem[rptr];
    // An empty FIFO never pops, so push+pop on empty is a plain push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/data_logger.sv
// rtl/data_logger.sv - per-channel sample averager/pass-through feeding a record FIFO
module data_logger
    import data_logger_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_CH   = 4,
    parameter int DEPTH    = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                enable,
    input  logic                                mode,
    input  logic                                clear,
    input  logic                                in_valid,
    input  logic [$clog2(NUM_CH)-1:0]           in_ch,
    input  logic [DATA_W-1:0]                   in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [rec_width(NUM_CH, DATA_W)-1:0] out_data,
    output logic [$clog2(DEPTH+1)-1:0]          level,
    output logic                                overflow
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int REC_W = rec_width(NUM_CH, DATA_W);
    localparam int ACC_W = DATA_W + AVG_LOG2;
    // A zero-width counter is not legal; with AVG_LOG2=0 every sample closes its window.
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic [ACC_W-1:0] acc [NUM_CH];
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic             mode_q;

    logic             mode_chg;
    logic             accept;
    logic [ACC_W-1:0] cur_acc;
    logic [CNT_W-1:0] cur_cnt;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] avg;
    logic             win_done;
    logic             push_req;
    logic [DATA_W-1:0] rec_val;
    logic [REC_W-1:0] push_data;
    logic             fifo_full;
    logic             fifo_empty;

    assign mode_chg = (mode != mode_q);
    assign accept   = in_valid && enable && !clear && ({1'b0, in_ch} < NUM_CH_L);

    // The edge that changes mode sees zeroed state, matching the flush it performs.
    assign cur_acc  = mode_chg ? '0 : acc[in_ch];
    assign cur_cnt  = mode_chg ? '0 : cnt[in_ch];
    assign sum      = cur_acc + ACC_W'(in_data);
    assign avg      = sum >> AVG_LOG2;
    assign win_done = (mode == MODE_PASS) || (cur_cnt == LAST_CNT);
    assign push_req = accept && win_done;
    assign rec_val  = (mode == MODE_PASS) ? in_data : avg[DATA_W-1:0];
    assign push_data = {in_ch, rec_val};

    assign out_valid = !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_AVG;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            mode_q <= mode;
            if (clear) begin
                overflow <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end
            end else begin
                if (mode_chg) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        acc[i] <= '0;
                        cnt[i] <= '0;
                    end
                end
                if (accept && mode == MODE_AVG) begin
                    if (win_done) begin
                        acc[in_ch] <= '0;
                        cnt[in_ch] <= '0;
                    end else begin
                        acc[in_ch] <= sum;
                        cnt[in_ch] <= cur_cnt + CNT_W'(1);
                    end
                end
                if (push_req && fifo_full && !(out_valid && out_ready)) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push_req),
        .wdata (push_data),
        .pop   (out_ready),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule

// File: doc/data_logger.md
DATA_LOGGER -- requirements
Module: data_logger

Interface
REQ-001 SHALL have parameter DATA_W, default 8: sample width in bits.
REQ-002 SHALL have parameter NUM_CH, default 4, range 2..16: number of input channels.
REQ-003 SHALL have parameter DEPTH, default 16, power of two ≥2: output FIFO depth in records.
REQ-004 SHALL have parameter AVG_LOG2, default 2, range 0..4: averaging window of 2^AVG_LOG2 samples per channel.
REQ-005 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-007 SHALL have port enable  input  1: samples are accepted only when high.
REQ-008 SHALL have port mode  input  1: 0 = AVG (windowed average), 1 = PASS (every sample logged).
REQ-009 SHALL have port clear  input  1: synchronous flush of all state.
REQ-010 SHALL have port in_valid  input  1: sample present.
REQ-011 SHALL have port in_ch  input  CH_W=clog2(NUM_CH): sample channel index.
REQ-012 SHALL have port in_data  input  DATA_W: sample value, unsigned.
REQ-013 SHALL have port out_valid  output  1: FIFO head record valid.
REQ-014 SHALL have port out_ready  input  1: consumer accepts head record.
REQ-015 SHALL have port out_data  output  CH_W+DATA_W: record {channel, value}, channel in MSBs.
REQ-016 SHALL have port level  output  clog2(DEPTH+1): current FIFO occupancy.
REQ-017 SHALL have port overflow  output  1: sticky, a record was dropped.

Function
REQ-018 SHALL accept a sample on a rising edge where in_valid=1, enable=1, clear=0 and in_ch<NUM_CH; all others are ignored without state change.
REQ-019 SHALL in AVG mode hold a per-channel accumulator of DATA_W+AVG_LOG2 bits and a per-channel count of AVG_LOG2 bits.
REQ-020 SHALL in AVG mode, on an accepted sample with count<2^AVG_LOG2-1, add in_data to that channel's accumulator and increment its count.
REQ-021 SHALL in AVG mode, on the accepted sample completing the window, push record {in_ch, (acc+in_data)>>AVG_LOG2} (truncating) and zero that channel's accumulator and count on the same edge.
REQ-022 SHALL in PASS mode push record {in_ch, in_data} for every accepted sample.
REQ-023 SHALL on any change of mode zero all accumulators and counts (partial windows discarded); the sample on the changing edge uses the new mode.
REQ-024 SHALL make a pushed record visible at out_valid/out_data on the cycle after the push edge when the FIFO was empty (latency 1).
REQ-025 SHALL present the FIFO first-word-fall-through: out_data is stable and valid whenever out_valid=1; pop occurs on an edge with out_valid=1 and out_ready=1.
REQ-026 SHALL accept a push when the FIFO is full only if a pop occurs on the same edge; level is then unchanged.
REQ-027 SHALL otherwise drop a push to a full FIFO, set overflow, and still clear the channel's accumulator and count.
REQ-028 SHALL treat simultaneous push and pop on an empty FIFO as a push only (no bypass).
REQ-029 SHALL on clear=1 empty the FIFO, zero all accumulators, counts and overflow, with priority over any sample or pop that cycle.
REQ-030 SHALL keep overflow set until clear or reset.

Reset
REQ-031 SHALL on rst_n low immediately drive out_valid=0, level=0, overflow=0 and zero all accumulators, counts and FIFO pointers.
REQ-032 SHALL discard any partial averaging window on reset mid-operation.
REQ-033 SHALL accept samples from the first rising edge after rst_n deasserts.

Structure
REQ-034 SHALL put in package data_logger_pkg: mode constants MODE_AVG=0, MODE_PASS=1 and a record-width function of NUM_CH and DATA_W.
REQ-035 SHALL implement the FIFO as sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level), all accumulation logic in data_logger.

Verification (DATA_W=8, NUM_CH=4, DEPTH=4, AVG_LOG2=2)
REQ-036 SHALL cover: AVG, ch1 samples 10,20,30,41 -> one record {1,25}, out_valid 1 cycle after 4th sample, level=1.
REQ-037 SHALL cover: AVG, interleaved ch0 4x100 and ch2 4x7 -> records {0,100} and {2,7} in window-completion order; no cross-channel mixing.
REQ-038 SHALL cover: PASS, out_ready=0, 5 samples 1..5 on ch3 -> level=4, overflow=1; draining yields 1,2,3,4.
REQ-039 SHALL cover: full FIFO with out_ready=1 and push same edge -> level stays 4, overflow stays 0, new record at tail.
REQ-040 SHALL cover: AVG, ch0 samples 200,200, rst_n pulsed low, then 4,8,12,16 -> single record {0,10}.
REQ-041 SHALL cover: clear asserted with in_valid=1 and out_ready=1 at level=3 -> level=0, out_valid=0, overflow=0, sample not counted.
